// File: rtl/rr_arbiter_with_hold_pkg.sv
// rr_arbiter_with_hold_pkg: shared arbiter state type and wrap-around first-set search
package rr_arbiter_with_hold_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int first_set_from(input logic [31:0] v, input int n, input int start);
    int idx;
    first_set_from = 0;
    for (int i = n - 1; i >= 0; i--) begin
      idx = start + i;
      if (idx >= n) idx = idx - n;
      if (v[idx]) first_set_from = idx;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter_with_hold_if.sv
// rr_arbiter_with_hold_if: request/grant bundle between requesters and the arbiter
interface rr_arbiter_with_hold_if #(parameter int N = 4);
  localparam int IW = $clog2(N);
  logic [N-1:0]  req;
  logic          en;
  logic          done;
  logic [N-1:0]  grant;
  logic          busy;
  logic [N-1:0]  pending;
  logic          timeout;
  logic [IW-1:0] timeout_ch;
  modport master (output req, en, done, input grant, busy, pending, timeout, timeout_ch);
  modport slave (input req, en, done, output grant, busy, pending, timeout, timeout_ch);
endinterface

// File: rtl/rr_arbiter_with_hold_pick.sv
// rr_priority_pick: combinational rotate-priority pick of the first set bit from ptr upward
module rr_priority_pick
  import rr_arbiter_with_hold_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);
  always_comb begin
    win_idx = IW'(first_set_from(32'(cand), N, int'(ptr)));
    win     = |cand ? N'(1) << win_idx : '0;
  end
endmodule

// File: rtl/rr_arbiter_with_hold.sv
// rr_arbiter_with_hold: round-robin arbiter with pending capture, transaction-length grants and hold timeout
module rr_arbiter_with_hold
  import rr_arbiter_with_hold_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  rr_arbiter_with_hold_if.slave  bus
);
  localparam int CW = $clog2(MAX_HOLD);
  localparam int IW = $clog2(N);
  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d, pending_q, pending_d;
  logic [IW-1:0] ptr_q, ptr_d, hold_ch_q, hold_ch_d, timeout_ch_q, timeout_ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [N-1:0]  cand, win;
  logic [IW-1:0] win_idx;
  logic          issue, release_now, force_rel;
  rr_priority_pick #(.N(N), .IW(IW)) u_pick (
    .cand    (cand),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );
  always_comb begin
    cand         = pending_q | bus.req;
    issue        = state_q == IDLE && bus.en && |cand;
    force_rel    = state_q == BUSY && !bus.done && cnt_q == CW'(MAX_HOLD - 1);
    release_now  = state_q == BUSY && (bus.done || force_rel);
    pending_d    = cand & ~(issue ? win : '0);
    state_d      = issue ? BUSY : release_now ? IDLE : state_q;
    grant_d      = issue ? win : release_now ? '0 : grant_q;
    cnt_d        = state_q == BUSY ? cnt_q + 1'b1 : '0;
    ptr_d        = issue ? (win_idx == IW'(N - 1) ? '0 : win_idx + 1'b1) : ptr_q;
    hold_ch_d    = issue ? win_idx : hold_ch_q;
    timeout_d    = force_rel;
    timeout_ch_d = force_rel ? hold_ch_q : timeout_ch_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      pending_q    <= '0;
      ptr_q        <= '0;
      hold_ch_q    <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      timeout_ch_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      hold_ch_q    <= hold_ch_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      timeout_ch_q <= timeout_ch_d;
    end
  end
  assign bus.grant      = grant_q;
  assign bus.busy       = |grant_q;
  assign bus.pending    = pending_q;
  assign bus.timeout    = timeout_q;
  assign bus.timeout_ch = timeout_ch_q;
endmodule

// File: tb/tb_rr_arbiter_with_hold.sv
// tb_rr_arbiter_with_hold: scoreboard bench for grant start, grant length and timeout events
module tb_rr_arbiter_with_hold;
  typedef struct {int kind; int val;} ev_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int tests = 0;
  int fails = 0;
  ev_t exp_q[$];
  logic [3:0] prev_grant = '0;
  int glen = 0;
  rr_arbiter_with_hold_if #(.N(4)) bus();
  rr_arbiter_with_hold #(.N(4), .MAX_HOLD(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  function automatic string kname(input int k);
    return k == 0 ? "grant_start" : k == 1 ? "grant_len" : "timeout_ch";
  endfunction
  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask
  task automatic sb_check(input int k, input int v);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected %s got=%0d expected=none", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        fails++;
        $display("FAIL %s got=%0d expected %s=%0d", kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.busy !== |bus.grant || !$onehot0(bus.grant)) begin
      tests++;
      fails++;
      $display("FAIL grant_invariant grant=%b busy=%b", bus.grant, bus.busy);
    end
    if (prev_grant != 0 && bus.grant != 0 && bus.grant != prev_grant) begin
      tests++;
      fails++;
      $display("FAIL grant_changed got=%b expected=%b", bus.grant, prev_grant);
    end
    if (prev_grant != 0 && bus.grant == 0) sb_check(1, glen);
    if (bus.timeout) sb_check(2, int'(bus.timeout_ch));
    if (prev_grant == 0 && bus.grant != 0) sb_check(0, int'(bus.grant));
    glen = bus.grant == 0 ? 0 : glen + 1;
    prev_grant = bus.grant;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input int len);
    repeat (len - 1) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask
  task automatic do_reset(input string tag);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk({tag, "_grant"}, int'(bus.grant), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_pending"}, int'(bus.pending), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
    chk({tag, "_timeout_ch"}, int'(bus.timeout_ch), 0);
  endtask
  initial begin
    bus.req  = '0;
    bus.en   = 1'b1;
    bus.done = 1'b0;
    tick();
    do_reset("rst");
    // single pulse on ch2, held 4 cycles
    push(0, 4'b0100); push(1, 4);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    serve(4);
    chk("pulse_pending", int'(bus.pending), 0);
    // ptr is now 3: ch3 wins over ch0/ch1
    push(0, 4'b1000); push(1, 2);
    push(0, 4'b0001); push(1, 1);
    push(0, 4'b0010); push(1, 1);
    bus.req = 4'b1011;
    tick();
    bus.req = '0;
    chk("ptr3_pending", int'(bus.pending), 4'b0011);
    serve(2);
    tick();
    serve(1);
    tick();
    serve(1);
    chk("ptr3_pending_empty", int'(bus.pending), 0);
    // all requesting: rotation 0,1,2,3,0
    do_reset("rst2");
    for (int k = 0; k < 5; k++) begin
      push(0, 1 << (k % 4));
      push(1, 2);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      serve(2);
    end
    bus.req = '0;
    do_reset("rst3");
    // timeout on ch1
    push(0, 4'b0010); push(1, 16); push(2, 1);
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    repeat (16) tick();
    chk("to_pulse", int'(bus.timeout), 1);
    chk("to_ch", int'(bus.timeout_ch), 1);
    chk("to_grant", int'(bus.grant), 0);
    tick();
    chk("to_pulse_end", int'(bus.timeout), 0);
    chk("to_ch_hold", int'(bus.timeout_ch), 1);
    // en gating
    do_reset("rst4");
    bus.en  = 1'b0;
    bus.req = 4'b1001;
    tick();
    bus.req = '0;
    tick();
    chk("en_grant", int'(bus.grant), 0);
    chk("en_pending", int'(bus.pending), 4'b1001);
    push(0, 4'b0001); push(1, 2);
    push(0, 4'b1000); push(1, 1);
    bus.en = 1'b1;
    tick();
    serve(2);
    tick();
    serve(1);
    chk("en_pending_empty", int'(bus.pending), 0);
    // re-request ch2 colliding with done, ptr=0 then 3 wraps to 2
    push(0, 4'b0100); push(1, 2);
    push(0, 4'b0100); push(1, 1);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    tick();
    bus.req  = 4'b0100;
    bus.done = 1'b1;
    tick();
    bus.req  = '0;
    bus.done = 1'b0;
    chk("coll_idle", int'(bus.grant), 0);
    chk("coll_pending", int'(bus.pending), 4'b0100);
    tick();
    serve(1);
    // reset mid-transaction, no timeout, ptr back to 0
    push(0, 4'b0001); push(1, 3);
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    tick();
    do_reset("rst_mid");
    for (int k = 0; k < 4; k++) begin
      push(0, 1 << k);
      push(1, 1);
    end
    bus.req = 4'b1111;
    tick();
    bus.req = '0;
    serve(1);
    for (int k = 1; k < 4; k++) begin
      tick();
      serve(1);
    end
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_with_hold.md
Name: rr_arbiter_with_hold

Overview:
- Round-robin arbiter that shares one multi-cycle resource between N requesters.
- Requests are captured into per-channel pending bits, so single-cycle request pulses are never lost.
- A grant is issued to one channel and held until the resource signals done, or until a hold timeout fires.
- Sits in front of the shared resource, next to the fixed-order pending arbiters, for channels that need fairness and transaction-length grants.

Parameters:
- N, 4, number of requesting channels (N >= 2).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release (MAX_HOLD >= 2).
- CW, $clog2(MAX_HOLD), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset. Synchronous, active-low.
- req  input  N  per-channel request; pulse or level, sampled every cycle.
- en  input  1  arbitration enable; gates new grants only.
- done  input  1  resource completion strobe for the current grant.
- grant  output  N  one-hot registered grant; all-zero when idle.
- busy  output  1  high while a grant is held.
- pending  output  N  registered pending-request vector.
- timeout  output  1  one-cycle pulse when a grant is force-released.
- timeout_ch  output  $clog2(N)  channel index of the last timeout; holds its value until the next timeout.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - grant=0, busy=0, pending=0, timeout=0, timeout_ch=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset during BUSY abandons the transaction with no timeout pulse.
- Pending update, every cycle:
  - pending_next = (pending | req) & ~win_mask.
  - win_mask is the one-hot of the channel granted this cycle (zero if none).
  - A req on the currently-held channel during BUSY sets its pending bit again; it is a new request.
- State IDLE:
  - cand = pending | req.
  - If en=1 and cand!=0: the winner is the first set bit of cand searching from ptr upward, wrapping N-1 -> 0.
  - Next edge: grant=onehot(winner), busy=1, counter=0, ptr=(winner+1) mod N, state=BUSY.
  - Latency: req sampled at edge t gives grant high after edge t (one cycle).
  - If en=0 or cand=0: stay IDLE, grant=0.
- State BUSY:
  - grant held constant; counter increments each cycle.
  - en is ignored (no revocation).
  - done=1: next edge grant=0, busy=0, state=IDLE.
  - done=0 and counter==MAX_HOLD-1: next edge grant=0, busy=0, timeout=1 for one cycle, timeout_ch=winner index, state=IDLE.
  - If done and the timeout condition occur on the same cycle, done wins and there is no timeout.
- Grant gap:
  - Leaving BUSY always passes through at least one IDLE cycle with grant=0.
  - Minimum request-to-request grant spacing is therefore 1 idle cycle.
- done in IDLE is ignored.
- Fairness:
  - ptr advances only on an issued grant.
  - With all channels continuously requesting, grants rotate 0,1,2,...,N-1,0.
- Invariants:
  - grant is always zero or one-hot.
  - busy == |grant.
  - A channel's pending bit is never cleared without that channel being granted.

Decomposition:
- Shared package: state enum (IDLE, BUSY) and a function returning the first set bit from a start index with wrap, also usable by other arbiters.
- One natural sub-module: rr_priority_pick (combinational N-bit rotate-priority pick, inputs cand and ptr, outputs one-hot winner and index). Instance it once.

Test Plan:
- Single pulse: req=4'b0100 for 1 cycle, done 3 cycles after grant -> grant=4'b0100 from the next cycle for 4 cycles, pending returns to 0, ptr=3.
- All request: req=4'b1111 held, done one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between grants.
- Timeout: MAX_HOLD=16, req[1] pulse, done never asserted -> grant=4'b0010 for exactly 16 cycles, then timeout=1 for one cycle with timeout_ch=1, grant=0.
- en gating: en=0 and req=4'b1001 pulsed -> no grant, pending=4'b1001. Raise en -> grant=4'b0001, then after done grant=4'b1000 with no further req.
- Re-request and collision: during BUSY on ch2, pulse req[2] and assert done in the same cycle -> pending[2]=1, one idle cycle, then ch2 is granted again (ptr=3, no other pending, so wrap-around selects 2).
- Reset mid-transaction: rstn=0 for one cycle while BUSY -> all outputs 0 on the next edge, no timeout pulse, ptr=0.
